control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath's control inputs (enables, bus selects,
//  Gra/Grb/BAout, read/write, alu_instruction) one state per clock.
//  It replaces the hand-sequenced stimulus used so far.
//  Runs fetch (T0-T2), then the execute sequence for ld, ldi, st, br, nop, halt.
//  Sits beside datapath in the CPU top; consumes MDR_Data and con_output from it.
// PARAMETERS
//  ALU_ADD   5'b00011  alu_instruction code for add (address/offset computation)
//  OP_LD     5'b00000  opcode field MDR_Data[31:27] for ld
//  OP_LDI    5'b00001  opcode for ldi
//  OP_ST     5'b00010  opcode for st
//  OP_BR     5'b10010  opcode for br
//  OP_NOP    5'b11001  opcode for nop
//  OP_HALT   5'b11010  opcode for halt
// PORTS
//  clk                  in   1   clock, all state changes on rising edge
//  rst_n                in   1   asynchronous active-low reset
//  MDR_Data             in   32  MDR contents; opcode sampled in FETCH_T2
//  con_output           in   1   branch condition from CON FF (latched in BR_T3)
//  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable   out 1 each  register loads
//  MAR_enable, MDR_enable, r_enable, con_enable                    out 1 each  register loads
//  read, write          out  1   memory read (MDR mux select) / memory write strobe
//  Gra, Grb, BAout      out  1   select-and-encode controls
//  PC_select, Z_LO_select, MDR_select, c_select, r_select          out 1 each  bus drivers
//  alu_instruction      out  5   ALU opcode; 0 when Z_enable is low
//  run                  out  1   1 = executing, 0 = halted or in reset
//  illegal_op           out  1   sticky: an unsupported opcode was fetched
//  present_state        out  5   state encoding, for debug/verification
// BEHAVIOUR
//  - Outputs decode combinationally from present_state (Moore).
//  - Sole exception: PC_enable in BR_T6 = con_output.
//  - Every output not listed for a state is 0.
//  - rst_n low: present_state=S_RESET immediately (also mid-instruction).
//    All outputs 0, run=0, illegal_op=0.
//  - First rising edge after release: S_RESET->FETCH_T0.
//  - Fetch:
//    FETCH_T0: PC_select, MAR_enable.
//    FETCH_T1: PC_increment_enable, read, MDR_enable.
//    FETCH_T2: MDR_select, IR_enable; next state chosen from MDR_Data[31:27].
//  - ldi: T3 Grb,BAout,Y_enable; T4 c_select,Z_enable,alu=ALU_ADD;
//    T5 Z_LO_select,Gra,r_enable -> FETCH_T0. 6 cycles total.
//  - ld: T3/T4 as ldi; T5 Z_LO_select,MAR_enable; T6 read,MDR_enable;
//    T7 MDR_select,Gra,r_enable -> FETCH_T0. 8 cycles.
//  - st: T3/T4 as ldi; T5 Z_LO_select,MAR_enable;
//    T6 Gra,r_select,MDR_enable (read=0); T7 write -> FETCH_T0. 8 cycles.
//  - br: T3 Gra,r_select,con_enable; T4 PC_select,Y_enable;
//    T5 c_select,Z_enable,alu=ALU_ADD; T6 Z_LO_select, PC_enable=con_output -> FETCH_T0. 7 cycles.
//  - nop: FETCH_T2 -> FETCH_T0 (3 cycles).
//  - halt: FETCH_T2 -> S_HALT; stays there with all outputs 0 and run=0, until rst_n.
//  - Unsupported opcode: executed as nop; illegal_op set at the FETCH_T2 edge.
//    illegal_op holds until reset.
//  - run=1 in every state except S_RESET and S_HALT.
//  - Unused state encodings: next state S_RESET, outputs 0.
//  - Never asserted together: read with write; two bus-select outputs in the same state.
// TESTING
//  1 rst_n low mid-BR_T5 -> all outputs 0 at once; after release, FETCH_T0 on 1st edge.
//  2 ldi (MDR_Data=32'h0880_0005) -> exact 6-state sequence; alu_instruction=00011 only in T4.
//  3 br, con_output=1 -> PC_enable=1 in BR_T6; con_output=0 -> PC_enable stays 0; 7 cycles.
//  4 ld then st back-to-back -> 8+8 cycles; read only in T1/T6 of ld; write only in st T7.
//  5 nop then opcode 5'b11111 -> each returns to FETCH_T0 after 3 cycles;
//    illegal_op=1 from the 2nd and stays 1.
//  6 halt -> S_HALT, run=0, outputs frozen at 0 for 50 cycles; rst_n pulse restarts fetch.

Source files
------------

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired Moore control unit that steps the datapath through
//            fetch and the ld/ldi/st/br/nop/halt execute sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_NOP  = 5'b11001,
  parameter logic [4:0] OP_HALT = 5'b11010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MDR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        illegal_op,
  output logic [4:0]  present_state
);

  typedef enum logic [4:0] {
    S_RESET  = 5'd0,
    FETCH_T0 = 5'd1,
    FETCH_T1 = 5'd2,
    FETCH_T2 = 5'd3,
    LDI_T3   = 5'd4,
    LDI_T4   = 5'd5,
    LDI_T5   = 5'd6,
    LD_T3    = 5'd7,
    LD_T4    = 5'd8,
    LD_T5    = 5'd9,
    LD_T6    = 5'd10,
    LD_T7    = 5'd11,
    ST_T3    = 5'd12,
    ST_T4    = 5'd13,
    ST_T5    = 5'd14,
    ST_T6    = 5'd15,
    ST_T7    = 5'd16,
    BR_T3    = 5'd17,
    BR_T4    = 5'd18,
    BR_T5    = 5'd19,
    BR_T6    = 5'd20,
    S_HALT   = 5'd21
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  opcode;
  logic        bad_opcode;
  logic        unused_mdr;

  assign opcode        = MDR_Data[31:27];
  assign unused_mdr    = ^MDR_Data[26:0];
  assign present_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      illegal_op <= 1'b0;
    end else begin
      state <= next_state;
      if (bad_opcode) begin
        illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state          = S_RESET;
    bad_opcode          = 1'b0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    con_enable          = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    BAout               = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    alu_instruction     = 5'b00000;
    run                 = 1'b0;

    case (state)
      S_RESET: begin
        next_state = FETCH_T0;
      end

      FETCH_T0: begin
        run        = 1'b1;
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
        next_state = FETCH_T1;
      end

      FETCH_T1: begin
        run                 = 1'b1;
        PC_increment_enable = 1'b1;
        read                = 1'b1;
        MDR_enable          = 1'b1;
        next_state          = FETCH_T2;
      end

      FETCH_T2: begin
        run        = 1'b1;
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
        // Unknown opcodes fall through to fetch, behaving like nop.
        case (opcode)
          OP_LD:   next_state = LD_T3;
          OP_LDI:  next_state = LDI_T3;
          OP_ST:   next_state = ST_T3;
          OP_BR:   next_state = BR_T3;
          OP_NOP:  next_state = FETCH_T0;
          OP_HALT: next_state = S_HALT;
          default: begin
            next_state = FETCH_T0;
            bad_opcode = 1'b1;
          end
        endcase
      end

      LDI_T3, LD_T3, ST_T3: begin
        run      = 1'b1;
        Grb      = 1'b1;
        BAout    = 1'b1;
        Y_enable = 1'b1;
        case (state)
          LDI_T3:  next_state = LDI_T4;
          LD_T3:   next_state = LD_T4;
          default: next_state = ST_T4;
        endcase
      end

      LDI_T4, LD_T4, ST_T4: begin
        run             = 1'b1;
        c_select        = 1'b1;
        Z_enable        = 1'b1;
        alu_instruction = ALU_ADD;
        case (state)
          LDI_T4:  next_state = LDI_T5;
          LD_T4:   next_state = LD_T5;
          default: next_state = ST_T5;
        endcase
      end

      LDI_T5: begin
        run         = 1'b1;
        Z_LO_select = 1'b1;
        Gra         = 1'b1;
        r_enable    = 1'b1;
        next_state  = FETCH_T0;
      end

      LD_T5, ST_T5: begin
        run         = 1'b1;
        Z_LO_select = 1'b1;
        MAR_enable  = 1'b1;
        next_state  = (state == LD_T5) ? LD_T6 : ST_T6;
      end

      LD_T6: begin
        run        = 1'b1;
        read       = 1'b1;
        MDR_enable = 1'b1;
        next_state = LD_T7;
      end

      LD_T7: begin
        run        = 1'b1;
        MDR_select = 1'b1;
        Gra        = 1'b1;
        r_enable   = 1'b1;
        next_state = FETCH_T0;
      end

      ST_T6: begin
        // read stays low so the MDR mux takes the register bus.
        run        = 1'b1;
        Gra        = 1'b1;
        r_select   = 1'b1;
        MDR_enable = 1'b1;
        next_state = ST_T7;
      end

      ST_T7: begin
        run        = 1'b1;
        write      = 1'b1;
        next_state = FETCH_T0;
      end

      BR_T3: begin
        run        = 1'b1;
        Gra        = 1'b1;
        r_select   = 1'b1;
        con_enable = 1'b1;
        next_state = BR_T4;
      end

      BR_T4: begin
        run        = 1'b1;
        PC_select  = 1'b1;
        Y_enable   = 1'b1;
        next_state = BR_T5;
      end

      BR_T5: begin
        run             = 1'b1;
        c_select        = 1'b1;
        Z_enable        = 1'b1;
        alu_instruction = ALU_ADD;
        next_state      = BR_T6;
      end

      BR_T6: begin
        run         = 1'b1;
        Z_LO_select = 1'b1;
        PC_enable   = con_output;
        next_state  = FETCH_T0;
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        next_state = S_RESET;
      end
    endcase
  end

endmodule

`default_nettype wire
